fir_serial_mac: RTL and testbench
=================================

Name: fir_serial_mac

Overview:
- Parametrised, time-multiplexed FIR successor to the fixed 17-tap parallel low-pass in the FM demodulator chain.
- One signed multiplier is shared across all taps through a sequential MAC loop.
- Coefficients are runtime-loadable; the output is rounded and saturated.
- Sits between the I/Q merge stage and the demodulator, using a valid/ready input handshake.

Parameters:
- WIDTH, 16: sample and output width, signed.
- COEF_W, 16: coefficient width, signed.
- NTAPS, 17: number of taps, 2..256.
- FRAC, 16: fractional bits of the coefficient format; output = sum >>> FRAC.
- ACC_W, 40: accumulator width; must be >= WIDTH+COEF_W+clog2(NTAPS).
- AW, clog2(NTAPS): coefficient address width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- in_valid, in, 1: in_data valid.
- in_ready, out, 1: block can accept a sample.
- in_data, in, WIDTH: input sample, signed.
- out_valid, out, 1: one-cycle pulse, out_data updated.
- out_data, out, WIDTH: filtered sample, signed.
- out_sat, out, 1: saturation occurred on the current out_data; updated with out_valid.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, AW: tap index k.
- coef_data, in, COEF_W: coefficient h[k], signed.
- coef_err, out, 1: one-cycle pulse when a coefficient write is rejected.
- busy, out, 1: FSM not in IDLE.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_sat=0, coef_err=0, busy=0, in_ready=1.
  - Delay line is zeroed; write pointer=0; accumulator=0; FSM=IDLE.
  - Coefficient memory is NOT reset; it must be loaded before use.
- Delay line: circular buffer of NTAPS samples.
  - An accepted sample is written at wr_ptr, and wr_ptr increments modulo NTAPS (NTAPS-1 wraps to 0).
  - x[n-k] is read at (wr_ptr_at_accept - k) mod NTAPS.
- FSM states: IDLE, MAC, FLUSH, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready: write the sample, clear the accumulator, set k=0, go to MAC.
  - MAC: one cycle per tap. Product p=h[k]*x[n-k] (full WIDTH+COEF_W bits) is registered, then added to the accumulator the next cycle, sign-extended to ACC_W. k increments. Leave after k=NTAPS-1.
  - FLUSH: 1 cycle, adds the last registered product.
  - OUT: 1 cycle; out_valid=1 and out_data/out_sat are updated; next state is IDLE.
- Latency: handshake at edge E0 gives out_valid high for the cycle following edge E0+NTAPS+2. Throughput is one sample per NTAPS+3 cycles.
- in_ready=0 in MAC, FLUSH and OUT, so in_valid is ignored there. in_ready returns to 1 on the first IDLE cycle; back-to-back samples are allowed.
- Rounding and saturation:
  - r = (acc + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift).
  - If r > 2^(WIDTH-1)-1, out_data = max and out_sat=1.
  - If r < -2^(WIDTH-1), out_data = min and out_sat=1.
  - Otherwise out_data=r and out_sat=0.
- Accumulation never wraps, given the ACC_W constraint.
- out_data and out_sat hold their values between out_valid pulses.
- Coefficient writes:
  - Accepted only when busy=0 and coef_addr<NTAPS; written at the clock edge.
  - A write is rejected (memory unchanged, coef_err pulses on the next cycle) if busy=1 or coef_addr>=NTAPS.
  - If coef_we and an in_valid handshake occur in the same IDLE cycle, the write takes effect before the MAC uses h[k], so the new coefficient is used.
- Reset mid-operation: aborts the MAC, no out_valid, delay line cleared.

Test Plan:
- Impulse:
  - Stimulus: load h[k]=k+1 for k=0..16; feed in_data=16384 followed by 16 zeros; FRAC=16.
  - Required: outputs round((k+1)*16384/65536), i.e. 0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4 (rounding half up).
  - Required: out_valid exactly 19 cycles after each handshake; in_ready low for 19 cycles.
- DC gain:
  - Stimulus: all h=16384; feed constant 4 continuously.
  - Required: outputs ramp 1,2,...,17; output 17 stays from the 17th sample onward; out_sat=0 throughout.
- Saturation:
  - Stimulus 1: all h=32767, input 32767. Required: out_data=32767, out_sat=1.
  - Stimulus 2: all h=32767, input -32768. Required: out_data=-32768, out_sat=1.
- Rounding:
  - Stimulus 1: h[0]=2, others 0; input 32767. Required: output 1 (65534/65536).
  - Stimulus 2: h[0]=1, others 0; input -32768. Required: output 0 (-0.5 rounds up).
- Coefficient write errors:
  - Stimulus 1: coef_we with coef_addr=17. Required: coef_err pulses; memory is unchanged.
  - Stimulus 2: coef_we while busy=1. Required: coef_err pulses; the filter output equals the output with the original coefficients.
- Wrap and reset:
  - Stimulus 1: stream 40 random samples. Required: every output matches a golden model (checks pointer wrap).
  - Stimulus 2: assert rst during MAC. Required: no out_valid; in_ready=1 the cycle after reset releases; the next impulse reproduces the clean impulse response.

Source files
------------

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one shared signed multiplier walks all taps per sample,
// then the sum is rounded half-up and saturated to the output width.
module fir_serial_mac #(
   parameter int WIDTH  = 16,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 17,
   parameter int FRAC   = 16,
   parameter int ACC_W  = 40,
   parameter int AW     = $clog2(NTAPS)
) (
   input  logic              clk,
   input  logic              rst,
   // Input handshake: a sample transfers on a rising edge where in_valid and
   // in_ready are both high; in_ready is high only in IDLE, in_valid is
   // ignored otherwise and in_data need only be stable when in_valid is high.
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_sat,
   input  logic              coef_we,
   input  logic [AW-1:0]     coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic              coef_err,
   output logic              busy,
   output logic [1:0]        dbg_state_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MAC   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   localparam int PW = WIDTH + COEF_W;
   localparam int RW = ACC_W + 1;

   localparam logic [AW-1:0]        LAST_TAP = AW'(NTAPS - 1);
   localparam logic signed [RW-1:0] RND_HALF = RW'(longint'(1) <<< (FRAC - 1));
   localparam logic signed [RW-1:0] OUT_MAX  = RW'((longint'(1) <<< (WIDTH - 1)) - 1);
   localparam logic signed [RW-1:0] OUT_MIN  = -OUT_MAX - RW'(1);

   logic [1:0]               state_q, state_d;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]            k_q, k_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [PW-1:0]     prod_q, prod_d;
   logic                     prod_vld_q, prod_vld_d;
   logic                     out_valid_q;
   logic [WIDTH-1:0]         out_data_q;
   logic                     out_sat_q;
   logic                     coef_err_q;

   logic signed [WIDTH-1:0]  dline_q [NTAPS];
   logic signed [COEF_W-1:0] coef_q  [NTAPS];

   logic                     handshake;
   logic                     coef_ok;
   logic signed [COEF_W-1:0] coef_rd;
   logic signed [WIDTH-1:0]  x_rd;
   logic signed [PW-1:0]     tap_prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [RW-1:0]     rnd_sum;
   logic signed [RW-1:0]     rnd_r;
   logic [WIDTH-1:0]         sat_data;
   logic                     sat_flag;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_TAP) ? '0 : p + AW'(1);
   endfunction

   function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
      return (p == '0) ? LAST_TAP : p - AW'(1);
   endfunction

   assign handshake = (state_q == ST_IDLE) && in_valid;
   assign coef_ok   = coef_we && (state_q == ST_IDLE) && (int'(coef_addr) < NTAPS);

   // Both operands widened to the full product width so the multiply is exact.
   assign coef_rd  = coef_q[k_q];
   assign x_rd     = dline_q[rd_ptr_q];
   assign tap_prod = PW'(coef_rd) * PW'(x_rd);
   assign prod_ext = prod_vld_q ? ACC_W'(prod_q) : '0;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      k_d        = k_q;
      acc_d      = acc_q;
      prod_d     = prod_q;
      prod_vld_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               wr_ptr_d = ptr_inc(wr_ptr_q);
               rd_ptr_d = wr_ptr_q;
               k_d      = '0;
               acc_d    = '0;
               state_d  = ST_MAC;
            end
         end
         ST_MAC: begin
            // Product of tap k is registered; tap k-1's product lands in acc now.
            prod_d     = tap_prod;
            prod_vld_d = 1'b1;
            acc_d      = acc_q + prod_ext;
            rd_ptr_d   = ptr_dec(rd_ptr_q);
            k_d        = k_q + AW'(1);
            if (k_q == LAST_TAP) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            acc_d   = acc_q + prod_ext;
            state_d = ST_OUT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Round half up, then clamp into the signed output range.
   always_comb begin
      rnd_sum  = RW'(acc_q) + RND_HALF;
      rnd_r    = rnd_sum >>> FRAC;
      sat_data = WIDTH'(rnd_r);
      sat_flag = 1'b0;
      if (rnd_r > OUT_MAX) begin
         sat_data = WIDTH'(OUT_MAX);
         sat_flag = 1'b1;
      end else if (rnd_r < OUT_MIN) begin
         sat_data = WIDTH'(OUT_MIN);
         sat_flag = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         k_q        <= k_d;
         acc_q      <= acc_d;
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         coef_err_q  <= 1'b0;
      end else begin
         out_valid_q <= (state_q == ST_OUT);
         coef_err_q  <= coef_we && !coef_ok;
         if (state_q == ST_OUT) begin
            out_data_q <= sat_data;
            out_sat_q  <= sat_flag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            dline_q[i] <= '0;
         end
      end else if (handshake) begin
         dline_q[wr_ptr_q] <= in_data;
      end
   end

   // Coefficients deliberately survive reset; software reloads them as needed.
   always_ff @(posedge clk) begin
      if (coef_ok) begin
         coef_q[coef_addr] <= coef_data;
      end
   end

   assign in_ready    = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_sat     = out_sat_q;
   assign coef_err    = coef_err_q;
   assign dbg_state_o = state_q;

   a_out_valid_pulse : assert property (@(posedge clk) disable iff (rst)
      out_valid_q |=> !out_valid_q);

   a_tap_in_range : assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_MAC) |-> (int'(k_q) < NTAPS));

endmodule

// File: tb/tb_fir_serial_mac.sv
// Randomized bench for fir_serial_mac against a direct-form convolution model
// over a sample history queue, with latency, handshake and coefficient checks.
module tb_fir_serial_mac;

   localparam int WIDTH  = 16;
   localparam int COEF_W = 16;
   localparam int NTAPS  = 17;
   localparam int FRAC   = 16;
   localparam int ACC_W  = 40;
   localparam int AW     = $clog2(NTAPS);

   localparam longint MAXV = (longint'(1) << (WIDTH - 1)) - 1;
   localparam longint MINV = -MAXV - 1;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic              out_sat;
   logic              coef_we;
   logic [AW-1:0]     coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic              coef_err;
   logic              busy;
   logic [1:0]        dbg_state;

   fir_serial_mac #(
      .WIDTH (WIDTH),
      .COEF_W(COEF_W),
      .NTAPS (NTAPS),
      .FRAC  (FRAC),
      .ACC_W (ACC_W),
      .AW    (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_sat    (out_sat),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .coef_err   (coef_err),
      .busy       (busy),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ov_cnt = 0;
   always @(negedge clk) if (out_valid) ov_cnt <= ov_cnt + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   longint         h_m[NTAPS];
   longint         hist_m[$];
   logic [WIDTH:0] exp_q[$];
   logic [WIDTH:0] last_exp;
   int             last_hs = 0;

   function automatic logic [WIDTH:0] model_out();
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < NTAPS; k++) begin
         if (k < hist_m.size()) acc += h_m[k] * hist_m[k];
      end
      r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
      if (r > MAXV) return {1'b1, WIDTH'(MAXV)};
      if (r < MINV) return {1'b0, WIDTH'(0)} | {1'b1, WIDTH'(MINV)};
      return {1'b0, WIDTH'(r)};
   endfunction

   // ---------------- driver tasks (start and end on a negedge) ----------------
   task automatic write_coef(input int addr, input longint data, input bit exp_ok);
      coef_we   = 1'b1;
      coef_addr = AW'(addr);
      coef_data = COEF_W'(data);
      @(posedge clk);
      #1 coef_we = 1'b0;
      if (exp_ok) h_m[addr] = data;
      @(negedge clk);
      check_eq("coef_err", coef_err, exp_ok ? 0 : 1);
      if (!exp_ok) begin
         @(negedge clk);
         check_eq("coef_err_pulse", coef_err, 0);
      end
   endtask

   task automatic feed(input longint x, input bit b2b);
      int wait_cyc;
      int lat;
      int low_cnt;
      logic [WIDTH:0] e;
      in_data  = WIDTH'(x);
      in_valid = 1'b1;
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (!in_ready) begin
         check_eq("in_ready_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (b2b) check_eq("throughput", cyc - last_hs, NTAPS + 3);
      last_hs = cyc;
      hist_m.push_front(x);
      if (hist_m.size() > NTAPS) void'(hist_m.pop_back());
      exp_q.push_back(model_out());
      lat = 0;
      low_cnt = 0;
      while (lat < 100) begin
         @(negedge clk);
         if (out_valid) break;
         if (!in_ready) low_cnt++;
         lat++;
      end
      if (!out_valid) begin
         check_eq("out_valid_timeout", 0, 1);
         void'(exp_q.pop_front());
         return;
      end
      check_eq("latency", lat, NTAPS + 2);
      check_eq("ready_low_cycles", low_cnt, NTAPS + 2);
      check_eq("ready_at_out", in_ready, 1);
      e = exp_q.pop_front();
      last_exp = e;
      check_eq("out_data", longint'($signed(out_data)), longint'($signed(e[WIDTH-1:0])));
      check_eq("out_sat", out_sat, e[WIDTH]);
   endtask

   task automatic impulse(input longint amp);
      feed(amp, 1'b0);
      for (int i = 1; i < NTAPS; i++) feed(0, 1'b1);
   endtask

   task automatic load_all(input longint v);
      for (int k = 0; k < NTAPS; k++) write_coef(k, v, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ov_before;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      repeat (3) @(negedge clk);

      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_out_sat", out_sat, 0);
      check_eq("rst_coef_err", coef_err, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      // Impulse through h[k]=k+1
      for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1, 1'b1);
      impulse(16384);

      // DC gain ramp
      load_all(16384);
      for (int i = 0; i < NTAPS + 3; i++) feed(4, i != 0);

      // Saturation both ways
      load_all(32767);
      for (int i = 0; i < NTAPS; i++) feed(32767, i != 0);
      for (int i = 0; i < NTAPS; i++) feed(-32768, i != 0);

      // Rounding edges
      load_all(0);
      write_coef(0, 2, 1'b1);
      feed(32767, 1'b0);
      write_coef(0, 1, 1'b1);
      feed(-32768, 1'b0);

      // Rejected writes: out-of-range address, then during MAC
      for (int k = 0; k < NTAPS; k++) write_coef(k, NTAPS - k, 1'b1);
      write_coef(NTAPS, 5000, 1'b0);
      write_coef((1 << AW) - 1, -5000, 1'b0);
      impulse(12000);
      fork
         feed(20000, 1'b0);
         begin
            repeat (5) @(negedge clk);
            check_eq("busy_in_mac", busy, 1);
            coef_we   = 1'b1;
            coef_addr = AW'(0);
            coef_data = COEF_W'(-20000);
            @(posedge clk);
            #1 coef_we = 1'b0;
            @(negedge clk);
            check_eq("coef_err_busy", coef_err, 1);
         end
      join
      feed(-15000, 1'b1);

      // Random coefficients and a long stream to exercise pointer wrap
      for (int k = 0; k < NTAPS; k++) write_coef(k, longint'($urandom_range(0, 8191)) - 4096, 1'b1);
      for (int i = 0; i < 40; i++) feed(longint'($urandom_range(0, 65535)) - 32768, i != 0);

      // Output holds between pulses
      repeat (3) @(negedge clk);
      check_eq("hold_out_data", longint'($signed(out_data)), longint'($signed(last_exp[WIDTH-1:0])));

      // Reset in the middle of MAC
      in_data  = WIDTH'(9000);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("busy_before_rst", busy, 1);
      ov_before = ov_cnt;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hist_m.delete();
      @(negedge clk);
      check_eq("ready_after_rst", in_ready, 1);
      check_eq("idle_after_rst", busy, 0);
      repeat (30) @(negedge clk);
      check_eq("no_out_after_rst", ov_cnt - ov_before, 0);
      impulse(16384);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
